// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads two bytes from byte-wide memory into the
// 16-bit IR (low byte first) while stepping the PC, with hold and timeout.
module fetch_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Mem_Ready,
  input  logic       Hold,
  output logic       Mem_RD,
  output logic [2:0] PC_FunSel,
  output logic       PC_E,
  output logic [2:0] IR_FunSel,
  output logic       IR_E,
  output logic       Busy,
  output logic       Done,
  output logic       Fault
);

  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD_LO = 3'b101;
  localparam logic [2:0] FS_LOAD_HI = 3'b110;
  localparam logic [3:0] TMO_LAST   = 4'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOW_WAIT  = 3'd1,
    S_HIGH_WAIT = 3'd2,
    S_DONE      = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] tmo_reg, tmo_next;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      tmo_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    Mem_RD     = 1'b0;
    PC_FunSel  = 3'b000;
    PC_E       = 1'b0;
    IR_FunSel  = 3'b000;
    IR_E       = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    Fault      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (Start) begin
          state_next = S_LOW_WAIT;
          tmo_next   = 4'd0;
        end
      end

      S_LOW_WAIT, S_HIGH_WAIT: begin
        Busy = 1'b1;
        // Hold freezes both the state and the timeout counter.
        if (!Hold) begin
          Mem_RD = 1'b1;
          if (Mem_Ready) begin
            IR_E       = 1'b1;
            IR_FunSel  = (state_reg == S_LOW_WAIT) ? FS_LOAD_LO : FS_LOAD_HI;
            PC_E       = 1'b1;
            PC_FunSel  = FS_INC;
            state_next = (state_reg == S_LOW_WAIT) ? S_HIGH_WAIT : S_DONE;
            tmo_next   = 4'd0;
          end else if (tmo_reg == TMO_LAST) begin
            state_next = S_FAULT;
            tmo_next   = 4'd0;
          end else begin
            tmo_next = tmo_reg + 4'd1;
          end
        end
      end

      S_DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        state_next = S_IDLE;
      end

      S_FAULT: begin
        Fault = 1'b1;
        if (Start) begin
          state_next = S_LOW_WAIT;
          tmo_next   = 4'd0;
        end
      end

      default: begin
        state_next = S_IDLE;
        tmo_next   = 4'd0;
      end
    endcase

    // Reset wins: nothing reaches the register block on the reset edge.
    if (Reset) begin
      Mem_RD    = 1'b0;
      PC_FunSel = 3'b000;
      PC_E      = 1'b0;
      IR_FunSel = 3'b000;
      IR_E      = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      Fault     = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer with a PC/IR register block
// and byte memory modelled around it.
module tb_fetch_sequencer;

  localparam int T = 4;

  logic       Clock = 1'b0;
  logic       Reset, Start, Mem_Ready, Hold;
  logic       Mem_RD, PC_E, IR_E, Busy, Done, Fault;
  logic [2:0] PC_FunSel, IR_FunSel;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  fetch_sequencer #(.FETCH_TIMEOUT(T)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mem_Ready(Mem_Ready),
    .Hold(Hold), .Mem_RD(Mem_RD), .PC_FunSel(PC_FunSel), .PC_E(PC_E),
    .IR_FunSel(IR_FunSel), .IR_E(IR_E), .Busy(Busy), .Done(Done), .Fault(Fault)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Environment: byte memory plus the PC and IR registers the DUT controls.
  logic [7:0]  mem [256];
  logic [15:0] pc_q, ir_q;
  logic        init_regs;

  always @(posedge Clock) begin
    if (init_regs) begin
      pc_q <= 16'h0010;
      ir_q <= 16'h0000;
    end else begin
      if (PC_E && PC_FunSel == 3'b001) pc_q <= pc_q + 16'd1;
      if (IR_E && IR_FunSel == 3'b101) ir_q[7:0] <= mem[pc_q[7:0]];
      else if (IR_E && IR_FunSel == 3'b110) ir_q[15:8] <= mem[pc_q[7:0]];
    end
  end

  typedef struct {
    bit          is_fault;
    int          start_edge;
    int          lat;
    logic [15:0] pc;
    logic [15:0] ir;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per Done pulse or Fault entry.
  initial begin : monitor
    exp_t e;
    bit   fault_d;
    int   busy_cnt;
    fault_d  = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge Clock);
      #2;
      if (Reset) begin
        busy_cnt = 0;
        fault_d  = 1'b0;
      end else begin
        if (Busy) busy_cnt++;
        if (Done || (Fault && !fault_d)) begin
          if (sb.size() == 0) begin
            chk("unexpected_completion", 32'(Done), 32'(0));
          end else begin
            e = sb.pop_front();
            chk("kind_fault", 32'(Fault), 32'(e.is_fault));
            chk("latency", 32'(cyc - e.start_edge), 32'(e.lat));
            chk("pc", 32'(pc_q), 32'(e.pc));
            chk("ir", 32'(ir_q), 32'(e.ir));
            chk("busy_cycles", 32'(busy_cnt), 32'(e.is_fault ? e.lat : e.lat + 1));
          end
          busy_cnt = 0;
        end
        fault_d = Fault;
        if (Busy && !Done && Hold) chk("hold_quiet", 32'({Mem_RD, PC_E, IR_E}), 32'(0));
        if (Busy && !Done && !Hold) chk("mem_rd", 32'(Mem_RD), 32'(1));
        if (!PC_E) chk("pc_funsel_off", 32'(PC_FunSel), 32'(0));
        else       chk("pc_funsel_inc", 32'(PC_FunSel), 32'(1));
        if (!IR_E) chk("ir_funsel_off", 32'(IR_FunSel), 32'(0));
        if (Fault) chk("fault_not_busy", 32'(Busy), 32'(0));
      end
    end
  end

  // Reference model state: what PC/IR should hold after each transaction.
  logic [15:0] m_pc, m_ir;
  int          txn = 0;

  task automatic phase(input int hc, input int nr);
    repeat (hc) begin
      Hold = 1'b1; Mem_Ready = 1'($urandom); @(negedge Clock);
    end
    for (int i = 0; i < nr; i++) begin
      Hold = 1'b0; Mem_Ready = 1'b0; @(negedge Clock);
    end
    if (nr < T) begin
      Hold = 1'b0; Mem_Ready = 1'b1; @(negedge Clock);
    end
    Mem_Ready = 1'b0;
  endtask

  // hl/hh: hold cycles before each byte; l/h: not-ready cycles (T means timeout).
  task automatic fetch(input int hl, input int l_in, input int hh, input int h_in);
    exp_t e;
    int   l, h;
    l = (l_in > T) ? T : l_in;
    h = (h_in > T) ? T : h_in;
    e.start_edge = cyc + 1;
    if (l == T) begin
      e.is_fault = 1'b1;
      e.lat      = hl + T;
    end else begin
      m_ir[7:0] = mem[m_pc[7:0]];
      m_pc      = m_pc + 16'd1;
      if (h == T) begin
        e.is_fault = 1'b1;
        e.lat      = hl + l + 1 + hh + T;
      end else begin
        m_ir[15:8] = mem[m_pc[7:0]];
        m_pc       = m_pc + 16'd1;
        e.is_fault = 1'b0;
        e.lat      = hl + l + 1 + hh + h + 1;
      end
    end
    e.pc = m_pc;
    e.ir = m_ir;
    sb.push_back(e);
    $display("txn %0d: hold_lo=%0d wait_lo=%0d hold_hi=%0d wait_hi=%0d -> %s lat=%0d pc=%h ir=%h",
             txn, hl, l, hh, h, e.is_fault ? "fault" : "done", e.lat, e.pc, e.ir);
    txn++;

    Start = 1'b1; Hold = 1'($urandom); Mem_Ready = 1'($urandom);
    @(negedge Clock);
    Start = 1'b0;
    phase(hl, l);
    if (l < T) phase(hh, h);
    if (!e.is_fault) begin
      // DONE cycle: Start here must be ignored.
      Start = 1'($urandom); Hold = 1'($urandom); Mem_Ready = 1'($urandom);
      @(negedge Clock);
      Start = 1'b0;
    end
    repeat ($urandom_range(0, 2)) begin
      Hold = 1'($urandom); Mem_Ready = 1'($urandom); @(negedge Clock);
    end
    Hold = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h34;
    mem[8'h11] = 8'h12;
    Reset = 1'b1; init_regs = 1'b1; Start = 1'b1; Hold = 1'b0; Mem_Ready = 1'b1;
    @(negedge Clock);
    #1;
    chk("reset_outputs", 32'({Mem_RD, PC_FunSel, PC_E, IR_FunSel, IR_E, Busy, Done, Fault}), 32'(0));
    @(negedge Clock);
    Reset = 1'b0; init_regs = 1'b0; Start = 1'b0; Mem_Ready = 1'b0;
    #1;
    chk("idle_outputs", 32'({Mem_RD, PC_FunSel, PC_E, IR_FunSel, IR_E, Busy, Done, Fault}), 32'(0));
    @(negedge Clock);
    m_pc = 16'h0010;
    m_ir = 16'h0000;

    fetch(0, 0, 0, 0);          // basic: IR=1234, PC=0012
    fetch(0, 3, 0, 2);          // memory wait
    fetch(0, 0, 0, T);          // timeout in HIGH_WAIT
    fetch(0, 0, 0, 0);          // re-fetch from FAULT
    fetch(0, T - 1, 0, T - 1);  // ready exactly on the last allowed cycle
    fetch(5, 0, 0, 0);          // hold with ready asserted
    fetch(0, T, 0, 0);          // timeout in LOW_WAIT
    fetch(2, 1, 3, T - 1);
    for (int n = 0; n < 40; n++)
      fetch($urandom_range(0, 2), $urandom_range(0, T), $urandom_range(0, 2), $urandom_range(0, T));

    // Reset in HIGH_WAIT with memory ready: no enables, no Done.
    Start = 1'b1; Hold = 1'b0; Mem_Ready = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    Reset = 1'b1; Mem_Ready = 1'b1;
    #1;
    chk("reset_pc_e", 32'(PC_E), 32'(0));
    chk("reset_ir_e", 32'(IR_E), 32'(0));
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("after_reset_outputs", 32'({Mem_RD, PC_FunSel, PC_E, IR_FunSel, IR_E, Busy, Done, Fault}), 32'(0));
    chk("after_reset_pc", 32'(pc_q), 32'(m_pc + 16'd1));
    chk("after_reset_ir_lo", 32'(ir_q[7:0]), 32'(mem[m_pc[7:0]]));
    repeat (4) begin
      @(negedge Clock);
      #1;
      chk("no_done_after_reset", 32'({Done, Busy}), 32'(0));
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control stage directly upstream of the 16-bit FunSel/E register block.
- Sequences one instruction fetch from byte-wide memory into the instruction register (IR).
- Drives the PC and IR register controls: PC increments per byte, IR loads the low byte then the high byte (little-endian).
- Adds a memory-ready handshake, hold/stall support and a wait timeout with fault reporting.

Parameters:
- FETCH_TIMEOUT, 8: number of consecutive not-ready, not-held cycles in a wait state before FAULT. Legal range 1..15; the counter is 4 bits.

Ports:
- Clock  in  1  system clock, all state changes on the rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clock.
- Start  in  1  request one instruction fetch; sampled in IDLE and FAULT only.
- Mem_Ready  in  1  memory byte at the current PC is valid this cycle.
- Hold  in  1  stall; freezes the sequencer in wait states.
- Mem_RD  out  1  memory read strobe.
- PC_FunSel  out  3  FunSel to the PC register.
- PC_E  out  1  enable to the PC register.
- IR_FunSel  out  3  FunSel to the IR register.
- IR_E  out  1  enable to the IR register.
- Busy  out  1  fetch in progress.
- Done  out  1  one-cycle pulse: IR holds the complete instruction.
- Fault  out  1  memory timeout occurred.

Behaviour:
- Register FunSel codes used: 001 = increment, 101 = load I[7:0] and keep the high byte, 110 = load I[15:8] and keep the low byte.
- Whenever an enable is 0, its FunSel output is 000.
- States are IDLE, LOW_WAIT, HIGH_WAIT, DONE and FAULT.
- Reset:
  - state goes to IDLE and the timeout counter to 0.
  - all outputs are 0 in the cycle after Reset is sampled.
  - Reset has priority over every other input; a fetch aborted mid-operation produces no enable pulse on the reset edge's cycle and no Done.
- IDLE: if Start=1, go to LOW_WAIT; otherwise stay. All outputs are 0.
- LOW_WAIT:
  - Mem_RD=1 unless Hold=1.
  - If Mem_Ready=1 and Hold=0, assert combinationally in the same cycle: IR_E=1, IR_FunSel=101, PC_E=1, PC_FunSel=001. Both registers capture on the same edge that moves the state to HIGH_WAIT.
- HIGH_WAIT: same as LOW_WAIT, except IR_FunSel=110 and the next state is DONE.
- DONE: Done=1 for exactly one cycle, then go to IDLE. Start is ignored in DONE.
- Hold=1 in a wait state:
  - state and timeout counter are frozen.
  - Mem_RD, PC_E and IR_E are all 0.
  - Mem_Ready is ignored.
  - Hold has no effect in IDLE, DONE or FAULT.
- Timeout:
  - The counter clears on entry to each wait state.
  - It increments on each wait cycle with Mem_Ready=0 and Hold=0.
  - If the counter equals FETCH_TIMEOUT-1, Mem_Ready=0 and Hold=0, the next state is FAULT and no enables are asserted.
  - Mem_Ready=1 in that same cycle wins: the normal transition is taken.
- FAULT:
  - Fault=1 and Busy=0.
  - The PC keeps any partial increment; the IR low byte may already have been updated.
  - Start=1 clears Fault on the next edge and goes to LOW_WAIT, re-fetching from the current PC. Only Reset or Start leaves FAULT.
- Busy=1 in LOW_WAIT, HIGH_WAIT and DONE.
- Minimum latency with Mem_Ready held high: Start sampled at edge N gives the low-byte load at edge N+1, the high-byte load at N+2, Done=1 in the cycle after N+2, and IDLE after N+3.
- Start held high continuously re-fetches back-to-back every 4 cycles: IDLE, LOW_WAIT, HIGH_WAIT, DONE.

Test Plan:
- Basic fetch:
  - Stimulus: PC=0x0010, IR=0x0000; memory bytes 0x34 then 0x12; Mem_Ready=1; Start pulse.
  - Response: IR=0x1234, PC=0x0012, Done pulses exactly once, 3 cycles after Start; Busy high for 3 cycles.
- Memory wait:
  - Stimulus: Mem_Ready low 3 cycles in LOW_WAIT and 2 cycles in HIGH_WAIT.
  - Response: Done arrives 8 cycles after Start; IR and PC are correct; no Fault.
- Timeout:
  - Stimulus: FETCH_TIMEOUT=4; Mem_Ready stuck at 0 in HIGH_WAIT.
  - Response: after 4 wait cycles Fault=1 and Busy=0; PC advanced by 1; then a Start with Mem_Ready=1 re-fetches.
- Timeout boundary:
  - Stimulus: Mem_Ready=1 exactly on cycle FETCH_TIMEOUT.
  - Response: no Fault; the normal transition is taken.
- Hold:
  - Stimulus: Hold=1 for 5 cycles in LOW_WAIT with Mem_Ready=1 throughout.
  - Response: enables and Mem_RD are 0 during Hold; no timeout; the fetch completes 3 cycles after Hold drops.
- Reset mid-fetch:
  - Stimulus: Reset asserted in HIGH_WAIT together with Mem_Ready=1.
  - Response: no IR/PC enables in that cycle; state is IDLE; all outputs 0; no Done.
